// File: rtl/a_and_b_tester.sv
// Self-test driver/checker for a 2-input AND unit with combinational (c1)
// and registered (c2) outputs; drives operand vectors and counts mismatches.
module a_and_b_tester #(
    parameter int unsigned NUM_VEC = 16,
    parameter int unsigned MODE    = 0,
    parameter logic [7:0]  SEED    = 8'hA5,
    parameter int unsigned ERR_W   = 8,
    localparam int unsigned VEC_W  = $clog2(NUM_VEC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_start,
    input  logic             pi_c1,
    input  logic             pi_c2,
    output logic             po_a,
    output logic             po_b,
    output logic             po_busy,
    output logic             po_done,
    output logic             po_pass,
    output logic [ERR_W-1:0] po_err_cnt,
    output logic [VEC_W-1:0] po_vec_cnt
);

    localparam int unsigned SUM_W = ERR_W + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             exp_q, exp_d;
    logic             exp_vld_q, exp_vld_d;

    logic             c1_fail;
    logic             c2_fail;
    logic [SUM_W-1:0] err_sum;
    logic [ERR_W-1:0] err_sat;

    // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Operand pair {a,b} for vector index k with the given LFSR state
    function automatic logic [1:0] vec_bits(input logic [VEC_W-1:0] k, input logic [7:0] l);
        logic [1:0] kk;
        kk = 2'(k);
        if (MODE == 1) return {l[0], l[1]};
        return kk;
    endfunction

    // Per-edge check results and saturating error accumulation
    always_comb begin
        c1_fail = (state_q == ST_RUN) && (pi_c1 != (a_q & b_q));
        c2_fail = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) && exp_vld_q
                  && (pi_c2 != exp_q);
        err_sum = {1'b0, err_q} + SUM_W'(c1_fail) + SUM_W'(c2_fail);
        err_sat = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_W'(err_sum);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        vec_d     = vec_q;
        lfsr_d    = lfsr_q;
        exp_d     = exp_q;
        exp_vld_d = exp_vld_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (pi_start) begin
                    state_d    = ST_RUN;
                    err_d      = '0;
                    vec_d      = VEC_W'(1);
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    {a_d, b_d} = vec_bits('0, SEED);
                    lfsr_d     = lfsr_step(SEED);
                    exp_vld_d  = 1'b0;
                end
            end
            ST_RUN: begin
                err_d     = err_sat;
                exp_d     = a_q & b_q;
                exp_vld_d = 1'b1;
                if (vec_q < VEC_W'(NUM_VEC)) begin
                    {a_d, b_d} = vec_bits(vec_q, lfsr_q);
                    lfsr_d     = lfsr_step(lfsr_q);
                    vec_d      = vec_q + VEC_W'(1);
                end else begin
                    state_d = ST_FLUSH;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end
            end
            ST_FLUSH: begin
                err_d     = err_sat;
                exp_vld_d = 1'b0;
                state_d   = ST_DONE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pass_d    = (err_sat == '0);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            vec_q     <= '0;
            lfsr_q    <= SEED;
            exp_q     <= 1'b0;
            exp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            vec_q     <= vec_d;
            lfsr_q    <= lfsr_d;
            exp_q     <= exp_d;
            exp_vld_q <= exp_vld_d;
        end
    end

    assign po_a       = a_q;
    assign po_b       = b_q;
    assign po_busy    = busy_q;
    assign po_done    = done_q;
    assign po_pass    = pass_q;
    assign po_err_cnt = err_q;
    assign po_vec_cnt = vec_q;

endmodule
